// File: rtl/tdes_ahb_pkg.sv
// Shared constants and types for the TDES AHB-Lite master: slave register map,
// AHB-Lite encodings and the master's FSM states.
package tdes_ahb_pkg;

  localparam logic [31:0] ADDR_A0 = 32'hAAAA_AAA0;  // mode
  localparam logic [31:0] ADDR_A1 = 32'hAAAA_AAA1;  // key1
  localparam logic [31:0] ADDR_A2 = 32'hAAAA_AAA2;  // key2
  localparam logic [31:0] ADDR_A3 = 32'hAAAA_AAA3;  // key3
  localparam logic [31:0] ADDR_A4 = 32'hAAAA_AAA4;  // data, starts the cipher
  localparam logic [31:0] ADDR_A5 = 32'hAAAA_AAA5;  // result

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HSIZE_64      = 3'b011;
  localparam logic [3:0] HPROT_DATA    = 4'h3;

  localparam int RESULT_WAIT_DEFAULT = 48;  // 16 rounds x 3 passes
  localparam logic [2:0] WR_IDX_LAST = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR,
    S_WR_LAST,
    S_WAIT,
    S_RD,
    S_RD_DATA,
    S_RD_CAPT,
    S_DONE,
    S_ERROR
  } state_e;

  // Write address phases walk A0..A4 in order.
  function automatic logic [31:0] wr_addr(input logic [2:0] idx);
    return ADDR_A0 + {29'd0, idx};
  endfunction

endpackage

// File: rtl/tdes_ahb_master_if.sv
// Point-to-point AHB-Lite link between the TDES master and the TDES slave.
interface tdes_ahb_master_if;

  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HBURST;
  logic [2:0]  HSIZE;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [63:0] HWDATA;
  logic        HREADY;
  logic        HRESP;
  logic [63:0] HRDATA;

  modport master (
    output HSEL, HADDR, HWRITE, HTRANS, HBURST, HSIZE, HPROT, HMASTLOCK, HWDATA,
    input  HREADY, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HWRITE, HTRANS, HBURST, HSIZE, HPROT, HMASTLOCK, HWDATA,
    output HREADY, HRESP, HRDATA
  );

endinterface

// File: rtl/tdes_ahb_master.sv
// AHB-Lite master running one Triple-DES job: five pipelined register writes,
// a fixed cipher wait, one result read, then a single-cycle done pulse.
module tdes_ahb_master
  import tdes_ahb_pkg::*;
#(
  parameter int RESULT_WAIT = RESULT_WAIT_DEFAULT
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        start,
  input  logic        encrypt_type,
  input  logic [63:0] key1_in,
  input  logic [63:0] key2_in,
  input  logic [63:0] key3_in,
  input  logic [63:0] data_in,
  output logic        busy,
  output logic        done,
  output logic [63:0] result,
  output logic        error,
  tdes_ahb_master_if.master bus
);

  localparam int WAIT_W = $clog2(RESULT_WAIT);

  state_e              r_state;
  state_e              w_next_state;
  logic [2:0]          r_idx;
  logic [WAIT_W-1:0]   r_wait;
  logic                r_mode;
  logic [63:0]         r_key1;
  logic [63:0]         r_key2;
  logic [63:0]         r_key3;
  logic [63:0]         r_data;
  logic [63:0]         r_result;
  logic                w_accept;
  logic [63:0]         w_prev_word;
  logic [31:0]         w_haddr;
  logic                w_hwrite;
  logic [1:0]          w_htrans;
  logic [63:0]         w_hwdata;

  assign w_accept = ((r_state == S_IDLE) || (r_state == S_ERROR)) && start;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    if (r_state != S_IDLE && r_state != S_ERROR && bus.HRESP) begin
      w_next_state = S_ERROR;
    end else begin
      case (r_state)
        S_IDLE, S_ERROR: if (start) w_next_state = S_WR;
        S_WR:      if (bus.HREADY && r_idx == WR_IDX_LAST) w_next_state = S_WR_LAST;
        S_WR_LAST: if (bus.HREADY) w_next_state = S_WAIT;
        S_WAIT:    if (r_wait == '0) w_next_state = S_RD;
        S_RD:      if (bus.HREADY) w_next_state = S_RD_DATA;
        S_RD_DATA: if (bus.HREADY) w_next_state = S_RD_CAPT;
        S_RD_CAPT: w_next_state = S_DONE;
        S_DONE:    w_next_state = S_IDLE;
        default:   w_next_state = S_IDLE;
      endcase
    end
  end

  // Data phase of write index n carries the word addressed at index n-1.
  always_comb begin
    w_prev_word = '0;
    case (r_idx)
      3'd1:    w_prev_word = {63'd0, r_mode};
      3'd2:    w_prev_word = r_key1;
      3'd3:    w_prev_word = r_key2;
      3'd4:    w_prev_word = r_key3;
      default: w_prev_word = '0;
    endcase
  end

  always_comb begin
    w_haddr  = '0;
    w_hwrite = 1'b0;
    w_htrans = HTRANS_IDLE;
    w_hwdata = '0;
    case (r_state)
      S_WR: begin
        w_haddr  = wr_addr(r_idx);
        w_hwrite = 1'b1;
        w_htrans = HTRANS_NONSEQ;
        w_hwdata = w_prev_word;
      end
      S_WR_LAST: w_hwdata = r_data;
      S_RD: begin
        w_haddr  = ADDR_A5;
        w_htrans = HTRANS_NONSEQ;
      end
      default: ;
    endcase
  end

  // NOTE: payload registers are reset along with control so the whole block
  // has a known state straight out of reset.
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      r_idx    <= '0;
      r_wait   <= '0;
      r_mode   <= 1'b0;
      r_key1   <= '0;
      r_key2   <= '0;
      r_key3   <= '0;
      r_data   <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_mode <= encrypt_type;
        r_key1 <= key1_in;
        r_key2 <= key2_in;
        r_key3 <= key3_in;
        r_data <= data_in;
        r_idx  <= '0;
      end
      if (r_state == S_WR && bus.HREADY && r_idx != WR_IDX_LAST) begin
        r_idx <= r_idx + 3'd1;
      end
      // WR_LAST is the first of the RESULT_WAIT idle cycles before the read.
      if (r_state == S_WR && w_next_state == S_WR_LAST) begin
        r_wait <= WAIT_W'(RESULT_WAIT - 1);
      end else if (((r_state == S_WR_LAST && bus.HREADY) || r_state == S_WAIT)
                   && r_wait != '0) begin
        r_wait <= r_wait - 1'b1;
      end
      if (r_state == S_RD_CAPT && w_next_state == S_DONE) begin
        r_result <= bus.HRDATA;
      end
    end
  end

  assign bus.HSEL      = 1'b1;
  assign bus.HADDR     = w_haddr;
  assign bus.HWRITE    = w_hwrite;
  assign bus.HTRANS    = w_htrans;
  assign bus.HBURST    = HBURST_SINGLE;
  assign bus.HSIZE     = HSIZE_64;
  assign bus.HPROT     = HPROT_DATA;
  assign bus.HMASTLOCK = 1'b0;
  assign bus.HWDATA    = w_hwdata;

  assign busy   = (r_state == S_WR) || (r_state == S_WR_LAST) || (r_state == S_WAIT)
               || (r_state == S_RD) || (r_state == S_RD_DATA) || (r_state == S_RD_CAPT);
  assign done   = (r_state == S_DONE);
  assign error  = (r_state == S_ERROR);
  assign result = r_result;

endmodule

// File: tb/tb_tdes_ahb_master.sv
// Bench for tdes_ahb_master: behavioural AHB slave with a reversible stand-in
// cipher, randomized jobs and stalls, plus directed error/restart/reset cases.
module tb_tdes_ahb_master;
  import tdes_ahb_pkg::*;

  localparam int W        = 48;
  localparam int DONE_CYC = 9 + W;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b0;
  logic        start = 1'b0;
  logic        encrypt_type = 1'b0;
  logic [63:0] key1_in = '0, key2_in = '0, key3_in = '0, data_in = '0;
  logic        busy, done, error;
  logic [63:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  tdes_ahb_master_if bus ();

  tdes_ahb_master #(.RESULT_WAIT(W)) dut (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .start        (start),
    .encrypt_type (encrypt_type),
    .key1_in      (key1_in),
    .key2_in      (key2_in),
    .key3_in      (key3_in),
    .data_in      (data_in),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .error        (error),
    .bus          (bus)
  );

  always #5 HCLK = ~HCLK;

  // Reversible stand-in for the TDES core: encrypt then decrypt restores data.
  function automatic logic [63:0] toy_cipher(input logic enc, input logic [63:0] k1,
                                             input logic [63:0] k2, input logic [63:0] k3,
                                             input logic [63:0] d);
    logic [63:0] x;
    if (enc) begin
      x = (d ^ k1) + k2;
      x = {x[50:0], x[63:51]};
      x = x ^ k3;
    end else begin
      x = d ^ k3;
      x = {x[12:0], x[63:13]};
      x = x - k2;
      x = x ^ k1;
    end
    return x;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // Behavioural slave: tracks address/data phases mid-cycle, logs transfers,
  // registers read data so it appears one cycle after the read data phase.
  logic [63:0] s_regs [8];
  logic [63:0] s_result = '0;
  logic [31:0] wr_addr_q [$];
  logic [63:0] wr_data_q [$];
  logic [31:0] rd_addr_q [$];
  bit          pend_v = 0, pend_w = 0, rd_next = 0;
  logic [31:0] pend_a = '0;

  initial begin
    bit rd_now;
    bus.HRDATA = '0;
    forever begin
      @(negedge HCLK);
      rd_now  = rd_next;
      rd_next = 0;
      bus.HRDATA = rd_now ? s_result : {$urandom, $urandom};
      if (!HRESET) begin
        pend_v = 0;
      end else if (bus.HREADY) begin
        if (pend_v) begin
          if (pend_w) begin
            wr_addr_q.push_back(pend_a);
            wr_data_q.push_back(bus.HWDATA);
            s_regs[pend_a[2:0]] = bus.HWDATA;
            if (pend_a == ADDR_A4)
              s_result = toy_cipher(s_regs[0][0], s_regs[1], s_regs[2], s_regs[3], bus.HWDATA);
          end else begin
            rd_addr_q.push_back(pend_a);
            rd_next = 1;
          end
        end
        pend_v = (bus.HTRANS == HTRANS_NONSEQ);
        pend_a = bus.HADDR;
        pend_w = bus.HWRITE;
      end
    end
  end

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
  endtask

  task automatic drive_job(input logic enc, input logic [63:0] k1, input logic [63:0] k2,
                           input logic [63:0] k3, input logic [63:0] d);
    encrypt_type = enc;
    key1_in = k1;
    key2_in = k2;
    key3_in = k3;
    data_in = d;
    start = 1'b1;
  endtask

  // One full job; cycle 0 is the current cycle, start sampled at its end.
  task automatic do_job(input string name, input logic enc, input logic [63:0] k1,
                        input logic [63:0] k2, input logic [63:0] k3, input logic [63:0] d,
                        input int stall_at, input int stall_len, input bit adds,
                        input int restart_at, output logic [63:0] res);
    logic [63:0] exp_res;
    logic [63:0] words [5];
    int exp_done, n_done, done_at;
    exp_res  = toy_cipher(enc, k1, k2, k3, d);
    exp_done = DONE_CYC + (adds ? stall_len : 0);
    words    = '{{63'd0, enc}, k1, k2, k3, d};
    n_done   = 0;
    done_at  = -1;
    res      = '0;
    clear_logs();
    drive_job(enc, k1, k2, k3, d);
    for (int j = 1; j <= exp_done + 4; j++) begin
      tick();
      start = (j == restart_at);
      if (start) drive_job(~enc, {$urandom, $urandom}, {$urandom, $urandom},
                           {$urandom, $urandom}, {$urandom, $urandom});
      bus.HREADY = !(j >= stall_at && j < stall_at + stall_len);
      if (j == 1) begin
        check({name, ".busy_c1"}, busy, 1);
        check({name, ".err_clr"}, error, 0);
      end
      if (adds && stall_at == 3 && j >= 3 && j < 3 + stall_len) begin
        check({name, ".frz_haddr"}, bus.HADDR, ADDR_A2);
        check({name, ".frz_htrans"}, bus.HTRANS, HTRANS_NONSEQ);
        check({name, ".frz_hwdata"}, bus.HWDATA, k1);
      end
      if (done) begin
        n_done++;
        if (done_at < 0) begin
          done_at = j;
          res = result;
          check({name, ".busy_at_done"}, busy, 0);
        end
      end
    end
    bus.HREADY = 1'b1;
    check({name, ".done_count"}, n_done, 1);
    check({name, ".done_cycle"}, done_at, exp_done);
    check({name, ".result"}, res, exp_res);
    check({name, ".result_hold"}, result, exp_res);
    check({name, ".n_writes"}, wr_addr_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < wr_addr_q.size()) begin
        check($sformatf("%s.wr%0d_addr", name, i), wr_addr_q[i], ADDR_A0 + i);
        check($sformatf("%s.wr%0d_data", name, i), wr_data_q[i], words[i]);
      end
    end
    check({name, ".n_reads"}, rd_addr_q.size(), 1);
    if (rd_addr_q.size() > 0) check({name, ".rd_addr"}, rd_addr_q[0], ADDR_A5);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] k1, k2, k3, pt, ct, res;
    int bad, n_done, region, len, at;
    k1 = 64'h0123456789ABCDEF;
    k2 = 64'h23456789ABCDEF01;
    k3 = 64'h456789ABCDEF0123;
    pt = 64'h5468652071756663;
    bus.HREADY = 1'b1;
    bus.HRESP  = 1'b0;

    // Reset state, including constant outputs.
    tick();
    tick();
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.error", error, 0);
    check("rst.result", result, 0);
    check("rst.haddr", bus.HADDR, 0);
    check("rst.hwrite", bus.HWRITE, 0);
    check("rst.htrans", bus.HTRANS, HTRANS_IDLE);
    check("rst.hwdata", bus.HWDATA, 0);
    check("rst.hsel", bus.HSEL, 1);
    check("rst.hburst", bus.HBURST, 3'b000);
    check("rst.hsize", bus.HSIZE, 3'b011);
    check("rst.hprot", bus.HPROT, 4'h3);
    check("rst.hmastlock", bus.HMASTLOCK, 0);
    HRESET = 1'b1;
    tick();

    do_job("enc", 1'b1, k1, k2, k3, pt, 0, 0, 1'b0, 0, ct);
    tick();
    do_job("dec", 1'b0, k1, k2, k3, ct, 0, 0, 1'b0, 0, res);
    check("dec.plaintext", res, pt);
    tick();
    do_job("stall_a2", 1'b1, k1, k2, k3, pt, 3, 3, 1'b1, 0, res);
    tick();
    do_job("restart", 1'b1, k3, k1, k2, ~pt, 0, 0, 1'b0, 20, res);
    tick();

    // HRESP during the A3 address phase.
    clear_logs();
    drive_job(1'b1, k1, k2, k3, pt);
    bad = 0;
    n_done = 0;
    for (int j = 1; j <= DONE_CYC + 8; j++) begin
      tick();
      start = 1'b0;
      bus.HRESP = (j == 4);
      if (j == 5) begin
        check("err.error", error, 1);
        check("err.busy", busy, 0);
        check("err.htrans", bus.HTRANS, HTRANS_IDLE);
      end
      if (j >= 5) begin
        if (done) n_done++;
        if (bus.HTRANS != HTRANS_IDLE || !error || busy) bad++;
      end
    end
    check("err.no_done", n_done, 0);
    check("err.sticky", bad, 0);
    check("err.no_read", rd_addr_q.size(), 0);
    do_job("after_err", 1'b0, k2, k3, k1, pt, 0, 0, 1'b0, 0, res);
    tick();

    // Asynchronous reset in the middle of WAIT.
    clear_logs();
    drive_job(1'b1, k1, k2, k3, pt);
    for (int j = 1; j <= 30; j++) begin
      tick();
      start = 1'b0;
    end
    check("arst.busy_before", busy, 1);
    #2;
    HRESET = 1'b0;
    #1;
    check("arst.busy", busy, 0);
    check("arst.done", done, 0);
    check("arst.error", error, 0);
    check("arst.result", result, 0);
    check("arst.haddr", bus.HADDR, 0);
    check("arst.hwrite", bus.HWRITE, 0);
    check("arst.htrans", bus.HTRANS, HTRANS_IDLE);
    check("arst.hwdata", bus.HWDATA, 0);
    tick();
    tick();
    HRESET = 1'b1;
    n_done = 0;
    for (int j = 0; j < 40; j++) begin
      tick();
      if (done || busy) n_done++;
    end
    check("arst.quiet", n_done, 0);
    check("arst.no_read", rd_addr_q.size(), 0);

    // Randomized jobs with one stall in the write, wait or read window.
    for (int n = 0; n < 6; n++) begin
      region = $urandom_range(0, 2);
      len    = $urandom_range(1, 3);
      case (region)
        0:       at = $urandom_range(1, 6);
        1:       at = $urandom_range(10, 44);
        default: at = $urandom_range(54, 55);
      endcase
      do_job($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), {$urandom, $urandom},
             {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
             at, len, region != 1, 0, res);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
